// File: rtl/wb_stage_pipe_pkg.sv
// Shared widths, constants and state encoding for the MEM->WB writeback stage.
// The state value doubles as the externally visible occupancy count.
package wb_stage_pipe_pkg;

    localparam int DEF_LANES  = 2;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    typedef logic [DEF_ADDR_W-1:0] RegAddrBus;
    typedef logic [DEF_DATA_W-1:0] RegBus;

    localparam logic  WriteEnable  = 1'b1;
    localparam logic  WriteDisable = 1'b0;
    localparam logic  RstEnable    = 1'b1;
    localparam RegBus ZeroWord     = '0;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wb_lane_sanitise.sv
// Cleans per-lane write enables of one bundle: drops writes to r0 and any
// write shadowed by a younger lane of the same bundle targeting the same register.
module wb_lane_sanitise
    import wb_stage_pipe_pkg::*;
#(
    parameter int LANES  = DEF_LANES,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic [LANES-1:0]        we_i,
    input  logic [LANES*ADDR_W-1:0] waddr_i,
    output logic [LANES-1:0]        we_o
);

    always_comb begin
        we_o = we_i;
        for (int i = 0; i < LANES; i++) begin
            if (waddr_i[i*ADDR_W +: ADDR_W] == '0)
                we_o[i] = WriteDisable;
            // Lane 0 is oldest, so only a higher-numbered lane can overwrite lane i.
            for (int j = i + 1; j < LANES; j++) begin
                if (we_i[j] && (waddr_i[j*ADDR_W +: ADDR_W] == waddr_i[i*ADDR_W +: ADDR_W]))
                    we_o[i] = WriteDisable;
            end
        end
    end

endmodule

// File: rtl/wb_stage_pipe.sv
// MEM->WB stage register for LANES writeback slots with valid/ready handshake,
// a one-entry skid buffer so in_ready never depends on out_ready, and flush.
module wb_stage_pipe
    import wb_stage_pipe_pkg::*;
#(
    parameter int LANES  = DEF_LANES,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES-1:0]        in_we,
    input  logic [LANES*ADDR_W-1:0] in_waddr,
    input  logic [LANES*DATA_W-1:0] in_wdata,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES-1:0]        out_we,
    output logic [LANES*ADDR_W-1:0] out_waddr,
    output logic [LANES*DATA_W-1:0] out_wdata,
    output logic [1:0]              occupancy
);

    logic [LANES-1:0] in_we_clean;

    wb_lane_sanitise #(
        .LANES  (LANES),
        .ADDR_W (ADDR_W)
    ) u_sanitise (
        .we_i    (in_we),
        .waddr_i (in_waddr),
        .we_o    (in_we_clean)
    );

    wb_state_e               state_q, state_d;
    logic [LANES-1:0]        main_we_q, main_we_d, skid_we_q, skid_we_d;
    logic [LANES*ADDR_W-1:0] main_waddr_q, main_waddr_d, skid_waddr_q, skid_waddr_d;
    logic [LANES*DATA_W-1:0] main_wdata_q, main_wdata_d, skid_wdata_q, skid_wdata_d;
    logic                    in_xfer, out_xfer;

    // Skid occupied exactly when FULL; decoded from registered state only.
    assign in_ready  = (state_q != ST_FULL) && (rst != RstEnable);
    assign out_valid = (state_q != ST_EMPTY);
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;

    assign out_we    = out_valid ? main_we_q : '0;
    assign out_waddr = main_waddr_q;
    assign out_wdata = main_wdata_q;
    assign occupancy = state_q;

    always_comb begin
        state_d      = state_q;
        main_we_d    = main_we_q;
        main_waddr_d = main_waddr_q;
        main_wdata_d = main_wdata_q;
        skid_we_d    = skid_we_q;
        skid_waddr_d = skid_waddr_q;
        skid_wdata_d = skid_wdata_q;

        case (state_q)
            ST_EMPTY: begin
                if (in_xfer) begin
                    main_we_d    = in_we_clean;
                    main_waddr_d = in_waddr;
                    main_wdata_d = in_wdata;
                    state_d      = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_xfer && out_xfer) begin
                    main_we_d    = in_we_clean;
                    main_waddr_d = in_waddr;
                    main_wdata_d = in_wdata;
                end else if (in_xfer) begin
                    skid_we_d    = in_we_clean;
                    skid_waddr_d = in_waddr;
                    skid_wdata_d = in_wdata;
                    state_d      = ST_FULL;
                end else if (out_xfer) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_xfer) begin
                    main_we_d    = skid_we_q;
                    main_waddr_d = skid_waddr_q;
                    main_wdata_d = skid_wdata_q;
                    state_d      = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        // Address/data keep their last value so the idle bus does not toggle.
        if (flush) begin
            state_d   = ST_EMPTY;
            main_we_d = '0;
            skid_we_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q      <= ST_EMPTY;
            main_we_q    <= '0;
            main_waddr_q <= '0;
            main_wdata_q <= '0;
            skid_we_q    <= '0;
            skid_waddr_q <= '0;
            skid_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            main_we_q    <= main_we_d;
            main_waddr_q <= main_waddr_d;
            main_wdata_q <= main_wdata_d;
            skid_we_q    <= skid_we_d;
            skid_waddr_q <= skid_waddr_d;
            skid_wdata_q <= skid_wdata_d;
        end
    end

endmodule
